// File: rtl/stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// stream_demux_1xn
//
// Registered 1-to-N stream demultiplexer with valid/ready handshakes.
// Each input word goes to the channel named by s_sel, or to every channel
// when s_bcast is set. Every channel owns a one-word holding register, so a
// stalled consumer only blocks words addressed to it (and broadcasts).
// Words whose select points past the last channel are accepted, discarded
// and counted in a saturating error counter.
//
// Parameters
//   WIDTH  data word width in bits (>=1)
//   N      number of output channels (2..16, any value)
//   CNT_W  width of the saturating drop counter
//   SEL_W  derived select width, not overridable
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous reset, active low
//   s_valid  input word valid
//   s_ready  input word can be taken this cycle (combinational)
//   s_data   input word
//   s_sel    destination channel (ignored when s_bcast=1)
//   s_bcast  copy the word to all channels
//   m_valid  per-channel output valid
//   m_ready  per-channel consumer ready
//   m_data   channel k occupies bits [k*WIDTH +: WIDTH]
//   err_cnt  number of words dropped for an out-of-range select
// -----------------------------------------------------------------------------
module stream_demux_1xn #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int CNT_W = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic [SEL_W-1:0]     s_sel,
  input  logic                 s_bcast,
  output logic [N-1:0]         m_valid,
  input  logic [N-1:0]         m_ready,
  output logic [N*WIDTH-1:0]   m_data,
  output logic [CNT_W-1:0]     err_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0] data_q [N];
  logic [WIDTH-1:0] data_d [N];
  logic [CNT_W-1:0] err_q, err_d;

  // ---------------------------------------------------------------------------
  // Routing decode
  // ---------------------------------------------------------------------------
  logic [N-1:0] free;      // register empty, or emptying on this edge
  logic [N-1:0] target;    // channels the current word wants to reach
  logic [N-1:0] load;      // channels actually written on this edge
  logic         sel_in_range;
  logic         accept;
  logic         drop;

  // Only reachable as false when N is not a power of two.
  assign sel_in_range = (int'(s_sel) < N);

  assign free = ~valid_q | m_ready;

  always_comb begin
    // NOTE: give every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    target = '0;
    if (s_bcast) begin
      target = '1;
    end else if (sel_in_range) begin
      target[s_sel] = 1'b1;
    end
  end

  // Every targeted channel must be free. An out-of-range word targets nothing,
  // so it is always accepted; a broadcast needs all channels, which keeps it
  // all-or-nothing.
  assign s_ready = rst_n && (&(free | ~target));

  assign accept = s_valid && s_ready;
  assign load   = target & {N{accept}};
  assign drop   = accept && !s_bcast && !sel_in_range;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;

    for (int k = 0; k < N; k++) begin
      if (load[k]) begin
        // A load wins over a drain: valid stays high and the word is
        // replaced on the same edge, so back-to-back words see no bubble.
        valid_d[k] = 1'b1;
        data_d[k]  = s_data;
      end else if (m_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    if (drop && (err_q != '1)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the data registers are reset as well, not just the valids,
      // because m_data is required to read zero after reset.
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
      err_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_valid = valid_q;
  assign err_cnt = err_q;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign m_data[g*WIDTH +: WIDTH] = data_q[g];
  end

endmodule
